// File: rtl/letc_core_lsu.sv
// Load/store unit between the M1/M2/WB pipeline and the data memory subsystem.
// Loads are extracted from the stage-1 read word, and stores are merged into that same word.
module letc_core_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_m1_valid,
    input  logic        i_m1_load,
    input  logic        i_m1_store,
    input  logic [1:0]  i_m1_size,
    input  logic        i_m1_unsigned,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_store_data,
    input  logic        i_m1_stall,
    input  logic        i_flush,
    input  logic        i_wb_commit,
    output logic        o_m1_fault,
    output logic        o_m2_ready,
    output logic        o_dmss0_req_load,
    output logic        o_dmss0_req_store,
    output logic [31:0] o_dmss0_req_addr,
    output logic        o_dmss0_req_stall,
    input  logic        i_dmss1_rsp_ready,
    input  logic [31:0] i_dmss1_rsp_load_data,
    output logic [31:0] o_dmss2_req_store_data,
    output logic        o_dmss2_req_commit,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_load_data
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_req_ok;
    logic        w_m1_issue;
    logic        w_wb_take;
    logic [31:0] w_shifted;
    logic [31:0] w_load_ext;
    logic [31:0] w_lane_mask;
    logic [31:0] w_lane_data;
    logic [31:0] w_merged;

    logic        r_m2_valid;
    logic        r_m2_store;
    size_e       r_m2_size;
    logic        r_m2_unsigned;
    logic [1:0]  r_m2_addr;
    logic [31:0] r_m2_store_data;

    logic        r_wb_valid;
    logic        r_wb_store;
    logic [31:0] r_wb_load_data;
    logic [31:0] r_wb_store_data;

    assign w_is_mem     = i_m1_valid & (i_m1_load | i_m1_store);
    assign w_misaligned = ((i_m1_size == SZ_HALF) & i_m1_addr[0])
                        | ((i_m1_size == SZ_WORD) & (i_m1_addr[1:0] != 2'b00))
                        |  (i_m1_size == SZ_RSVD);
    assign o_m1_fault   = w_is_mem & w_misaligned;

    assign w_req_ok          = i_m1_valid & ~o_m1_fault & ~i_flush;
    assign w_m1_issue        = w_req_ok & (i_m1_load | i_m1_store);
    assign o_dmss0_req_load  = w_m1_issue;
    assign o_dmss0_req_store = w_req_ok & i_m1_store;
    assign o_dmss0_req_addr  = i_m1_addr;
    assign o_dmss0_req_stall = i_m1_stall | ~i_dmss1_rsp_ready;
    assign o_m2_ready        = i_dmss1_rsp_ready;

    // When only M1 is stalled, M2 still drains into WB, so M2 must become a bubble
    // rather than present the same instruction again next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m2_valid      <= 1'b0;
            r_m2_store      <= 1'b0;
            r_m2_size       <= SZ_BYTE;
            r_m2_unsigned   <= 1'b0;
            r_m2_addr       <= 2'b00;
            r_m2_store_data <= 32'h0;
        end else if (i_flush) begin
            r_m2_valid <= 1'b0;
        end else if (!o_dmss0_req_stall) begin
            r_m2_valid      <= w_m1_issue;
            r_m2_store      <= i_m1_store;
            r_m2_size       <= size_e'(i_m1_size);
            r_m2_unsigned   <= i_m1_unsigned;
            r_m2_addr       <= i_m1_addr[1:0];
            r_m2_store_data <= i_m1_store_data;
        end else if (i_dmss1_rsp_ready) begin
            r_m2_valid <= 1'b0;
        end
    end

    always_comb begin
        w_shifted = i_dmss1_rsp_load_data >> {r_m2_addr, 3'b000};
        case (r_m2_size)
            SZ_BYTE: w_load_ext = {{24{w_shifted[7] & ~r_m2_unsigned}}, w_shifted[7:0]};
            SZ_HALF: w_load_ext = {{16{w_shifted[15] & ~r_m2_unsigned}}, w_shifted[15:0]};
            default: w_load_ext = i_dmss1_rsp_load_data;
        endcase
    end

    // Replicating the store data across all lanes lets a shifted mask pick the target lane(s).
    always_comb begin
        w_lane_mask = 32'hFFFF_FFFF;
        w_lane_data = r_m2_store_data;
        case (r_m2_size)
            SZ_BYTE: begin
                w_lane_mask = 32'h0000_00FF << {r_m2_addr, 3'b000};
                w_lane_data = {4{r_m2_store_data[7:0]}};
            end
            SZ_HALF: begin
                w_lane_mask = 32'h0000_FFFF << {r_m2_addr[1], 4'b0000};
                w_lane_data = {2{r_m2_store_data[15:0]}};
            end
            default: begin
                w_lane_mask = 32'hFFFF_FFFF;
                w_lane_data = r_m2_store_data;
            end
        endcase
        w_merged = (i_dmss1_rsp_load_data & ~w_lane_mask) | (w_lane_data & w_lane_mask);
    end

    assign w_wb_take = r_m2_valid & i_dmss1_rsp_ready & ~i_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid      <= 1'b0;
            r_wb_store      <= 1'b0;
            r_wb_load_data  <= 32'h0;
            r_wb_store_data <= 32'h0;
        end else begin
            r_wb_valid      <= w_wb_take;
            r_wb_store      <= w_wb_take & r_m2_store;
            r_wb_load_data  <= (w_wb_take & ~r_m2_store) ? w_load_ext : 32'h0;
            r_wb_store_data <= (w_wb_take &  r_m2_store) ? w_merged   : 32'h0;
        end
    end

    assign o_wb_valid             = r_wb_valid;
    assign o_wb_load_data         = r_wb_load_data;
    assign o_dmss2_req_store_data = r_wb_store_data;
    assign o_dmss2_req_commit     = rst_n & r_wb_valid & r_wb_store & i_wb_commit;

endmodule

// File: tb/tb_letc_core_lsu.sv
// Directed scoreboard bench for letc_core_lsu with a small DMSS memory model.
// Expected WB results are queued at issue and compared when WB presents them.
module tb_letc_core_lsu;

    logic        clk = 1'b0;
    logic        rstN;
    logic        m1Valid, m1Load, m1Store, m1Unsigned, m1Stall, flush, wbCommit;
    logic [1:0]  m1Size;
    logic [31:0] m1Addr, m1StoreData;
    logic        m1Fault, m2Ready, reqLoad, reqStore, reqStall, rspReady, commit, wbValid;
    logic [31:0] reqAddr, rspData, storeData, wbLoadData;

    logic        preloadEn;
    logic [7:0]  preloadIdx;
    logic [31:0] preloadData;
    logic [31:0] mem [0:255];
    logic [31:0] s1Addr, s2Addr;

    typedef struct {
        logic        isStore;
        logic [31:0] loadData;
        logic [31:0] storeData;
        logic        commitAllowed;
        int          due;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    string    tagQ[$];
    int       assertCount = 0;
    int       failCount = 0;
    int       cycleCount = 0;

    always #5 clk = ~clk;

    letc_core_lsu dut (
        .clk                    (clk),
        .rst_n                  (rstN),
        .i_m1_valid             (m1Valid),
        .i_m1_load              (m1Load),
        .i_m1_store             (m1Store),
        .i_m1_size              (m1Size),
        .i_m1_unsigned          (m1Unsigned),
        .i_m1_addr              (m1Addr),
        .i_m1_store_data        (m1StoreData),
        .i_m1_stall             (m1Stall),
        .i_flush                (flush),
        .i_wb_commit            (wbCommit),
        .o_m1_fault             (m1Fault),
        .o_m2_ready             (m2Ready),
        .o_dmss0_req_load       (reqLoad),
        .o_dmss0_req_store      (reqStore),
        .o_dmss0_req_addr       (reqAddr),
        .o_dmss0_req_stall      (reqStall),
        .i_dmss1_rsp_ready      (rspReady),
        .i_dmss1_rsp_load_data  (rspData),
        .o_dmss2_req_store_data (storeData),
        .o_dmss2_req_commit     (commit),
        .o_wb_valid             (wbValid),
        .o_wb_load_data         (wbLoadData)
    );

    // DMSS model: stage 1 reads the word of the held address, stage 2 writes committed stores.
    always @(posedge clk) begin
        if (!reqStall) s1Addr <= reqAddr;
        if (rspReady) s2Addr <= s1Addr;
        if (commit) mem[s2Addr[9:2]] <= storeData;
        else if (preloadEn) mem[preloadIdx] <= preloadData;
    end
    assign rspData = mem[s1Addr[9:2]];

    function automatic logic [31:0] refLoad(input logic [1:0] size, input logic uns,
                                            input logic [1:0] lane, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (size == 2'b00) return uns ? {24'h0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] refMerge(input logic [1:0] size, input logic [1:0] lane,
                                             input logic [31:0] sd, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (size == 2'b00) begin
            case (lane)
                2'd0: r[7:0]   = sd[7:0];
                2'd1: r[15:8]  = sd[7:0];
                2'd2: r[23:16] = sd[7:0];
                default: r[31:24] = sd[7:0];
            endcase
        end else if (size == 2'b01) begin
            if (lane[1]) r[31:16] = sd[15:0];
            else r[15:0] = sd[15:0];
        end else begin
            r = sd;
        end
        return r;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleM1();
        m1Valid = 1'b0; m1Load = 1'b0; m1Store = 1'b0; m1Size = 2'b00;
        m1Unsigned = 1'b0; m1Addr = 32'h0; m1StoreData = 32'h0;
    endtask

    task automatic applyStimulus(input string tag, input logic isStore, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] memWord, input logic commitAllowed,
                                 input int extra, input logic expectWb);
        sbEntry_t e;
        m1Valid = 1'b1; m1Load = ~isStore; m1Store = isStore; m1Size = size;
        m1Unsigned = uns; m1Addr = addr; m1StoreData = sd;
        if (expectWb) begin
            e.isStore       = isStore;
            e.loadData      = isStore ? 32'h0 : refLoad(size, uns, addr[1:0], memWord);
            e.storeData     = isStore ? refMerge(size, addr[1:0], sd, memWord) : 32'h0;
            e.commitAllowed = commitAllowed;
            e.due           = cycleCount + 2 + extra;
            sbQ.push_back(e);
            tagQ.push_back(tag);
        end
    endtask

    task automatic checkOutput();
        sbEntry_t e;
        string    tag;
        if (wbValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                checkEq("unexpected_wb_valid", wbValid, 32'h0);
            end else begin
                e = sbQ.pop_front();
                tag = tagQ.pop_front();
                wbCommit = e.commitAllowed;
                #1;
                checkEq({tag, "_due"}, cycleCount, e.due);
                checkEq({tag, "_load"}, wbLoadData, e.loadData);
                checkEq({tag, "_sdata"}, storeData, e.storeData);
                checkEq({tag, "_commit"}, commit, {31'h0, e.isStore & e.commitAllowed});
            end
        end else begin
            wbCommit = 1'b1;
            #1;
            checkEq("idle_commit", commit, 32'h0);
            if (sbQ.size() != 0 && sbQ[0].due <= cycleCount) begin
                e = sbQ.pop_front();
                tag = tagQ.pop_front();
                checkEq({tag, "_missing"}, wbValid, 32'h1);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic drain();
        idleM1();
        cycle();
        cycle();
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        preloadIdx = addr[9:2];
        preloadData = data;
        preloadEn = 1'b1;
        cycle();
        preloadEn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; idleM1(); flush = 1'b0; m1Stall = 1'b0; wbCommit = 1'b0; rspReady = 1'b1;
        preloadEn = 1'b0; preloadIdx = 8'h0; preloadData = 32'h0;
        @(posedge clk);
        #1;
        preload(32'h100, 32'h80FF_1234);
        preload(32'h200, 32'h1122_3344);
        preload(32'h300, 32'h0000_0000);

        wbCommit = 1'b1;
        #1;
        checkEq("reset_wb_valid", wbValid, 32'h0);
        checkEq("reset_wb_load_data", wbLoadData, 32'h0);
        checkEq("reset_store_data", storeData, 32'h0);
        checkEq("reset_commit", commit, 32'h0);
        applyStimulus("reset_sh", 1'b1, 2'b01, 1'b0, 32'h203, 32'h1, 32'h0, 1'b0, 0, 1'b0);
        #1;
        checkEq("reset_fault_comb", m1Fault, 32'h1);
        idleM1();
        rstN = 1'b1;
        cycle();

        // Byte loads with sign and zero extension
        applyStimulus("lb_103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("lbu_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 1'b0, 0, 1'b1);
        cycle();
        drain();

        // Half, word and lane-0 loads back to back
        preload(32'h100, 32'h8001_5678);
        applyStimulus("lh_102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("lhu_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("lb_100", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        drain();

        // Stores: committed, uncommitted, and read back through the memory model
        applyStimulus("sb_commit", 1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFF_FFAB, 32'h1122_3344, 1'b1, 0, 1'b1);
        cycle();
        drain();
        applyStimulus("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122_AB44, 1'b0, 0, 1'b1);
        cycle();
        drain();
        preload(32'h200, 32'h1122_3344);
        applyStimulus("sb_nocommit", 1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFF_FFAB, 32'h1122_3344, 1'b0, 0, 1'b1);
        cycle();
        drain();
        applyStimulus("lw_after_nocommit", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122_3344, 1'b0, 0, 1'b1);
        cycle();
        drain();
        applyStimulus("sh_commit", 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF, 32'h1122_3344, 1'b1, 0, 1'b1);
        #1;
        checkEq("sh_fault", m1Fault, 32'h0);
        checkEq("sh_req_load", reqLoad, 32'h1);
        checkEq("sh_req_store", reqStore, 32'h1);
        checkEq("sh_req_addr", reqAddr, 32'h202);
        cycle();
        drain();

        // Faulting accesses never request and never reach WB
        applyStimulus("sh_203", 1'b1, 2'b01, 1'b0, 32'h203, 32'h1234, 32'h0, 1'b1, 0, 1'b0);
        #1;
        checkEq("sh203_fault", m1Fault, 32'h1);
        checkEq("sh203_req_load", reqLoad, 32'h0);
        checkEq("sh203_req_store", reqStore, 32'h0);
        cycle();
        applyStimulus("rsvd_size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        #1;
        checkEq("rsvd_fault", m1Fault, 32'h1);
        checkEq("rsvd_req_load", reqLoad, 32'h0);
        cycle();
        applyStimulus("lw_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        #1;
        checkEq("lw102_fault", m1Fault, 32'h1);
        cycle();
        drain();

        // Aliasing store then load with one DMSS not-ready cycle
        applyStimulus("alias_sw", 1'b1, 2'b10, 1'b0, 32'h300, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, 1'b1);
        cycle();
        applyStimulus("alias_lw", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);
        cycle();
        idleM1();
        rspReady = 1'b0;
        #1;
        checkEq("alias_stall", reqStall, 32'h1);
        checkEq("alias_m2_ready", m2Ready, 32'h0);
        cycle();
        rspReady = 1'b1;
        checkEq("alias_bubble", wbValid, 32'h0);
        cycle();
        cycle();

        // M1 stall alone must not duplicate the instruction draining from M2
        applyStimulus("stall_a", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("stall_b", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hBEEF_3344, 1'b0, 1, 1'b1);
        m1Stall = 1'b1;
        #1;
        checkEq("m1stall_req_stall", reqStall, 32'h1);
        cycle();
        m1Stall = 1'b0;
        cycle();
        drain();

        // Flush with a store in M2 (and DMSS not ready), then flush of an M1 load
        applyStimulus("flush_sw", 1'b1, 2'b10, 1'b0, 32'h300, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
        cycle();
        idleM1();
        flush = 1'b1;
        rspReady = 1'b0;
        cycle();
        flush = 1'b0;
        rspReady = 1'b1;
        checkEq("flush_wb_valid", wbValid, 32'h0);
        cycle();
        cycle();
        applyStimulus("flush_m1", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        flush = 1'b1;
        #1;
        checkEq("flush_req_load", reqLoad, 32'h0);
        cycle();
        flush = 1'b0;
        drain();
        applyStimulus("lw_after_flush", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1);
        cycle();
        drain();

        // Reset in the middle of a stream
        applyStimulus("rst_a", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001_5678, 1'b0, 0, 1'b1);
        cycle();
        applyStimulus("rst_b", 1'b1, 2'b10, 1'b0, 32'h200, 32'h55AA_55AA, 32'hBEEF_3344, 1'b1, 0, 1'b0);
        cycle();
        idleM1();
        rstN = 1'b0;
        cycle();
        wbCommit = 1'b1;
        #1;
        checkEq("midrst_wb_valid", wbValid, 32'h0);
        checkEq("midrst_wb_load_data", wbLoadData, 32'h0);
        checkEq("midrst_store_data", storeData, 32'h0);
        checkEq("midrst_commit", commit, 32'h0);
        rstN = 1'b1;
        cycle();
        cycle();

        checkEq("scoreboard_empty", sbQ.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
